hdmi_proc_ctrl: RTL and testbench

Frame-synchronous configuration controller for the HDMI pixel-processing datapath. It debounces the board push-button, classifies each press as short or long, and maintains a shadow configuration: processing mode and a 4-bit gray offset. It commits the shadow to the active outputs only at the rising edge of `vs_in`, so the gray/threshold datapath never changes settings mid-frame. It sits beside the pixel datapath in the `pixclk_in` domain and replaces the raw single-cycle `key_flag` feed.

---
 rtl/hdmi_proc_ctrl.sv | 152 +++++++++++++++
 tb/tb_hdmi_proc_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_proc_ctrl.sv
// Push-button configuration controller for the HDMI pixel datapath: debounces the key,
// classifies short/long presses into a shadow mode/offset, and commits it on the vs_in rising edge.
module hdmi_proc_ctrl #(
  parameter int unsigned DEB_CYCLES  = 1485000,
  parameter int unsigned LONG_CYCLES = 74250000
) (
  input  logic       pixclk_in,
  input  logic       rst,
  input  logic       key_n,
  input  logic       vs_in,
  output logic [1:0] mode,
  output logic [3:0] offset,
  output logic       cfg_update,
  output logic       pending
);

  localparam int unsigned CNT_MAX = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEB_DN,
    S_HELD,
    S_LONG_DONE,
    S_DEB_UP
  } key_state_e;

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             key_meta_q, key_s_q, vs_d_q;
  logic [1:0]       sh_mode_q, sh_mode_d, mode_q;
  logic [3:0]       sh_offset_q, sh_offset_d, offset_q;
  logic             cfg_update_q, pending_q;
  logic             short_evt, long_evt, frame_edge, changed;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    short_d   = short_q;
    short_evt = 1'b0;
    long_evt  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!key_s_q) begin
          cnt_d   = '0;
          state_d = S_DEB_DN;
        end
      end
      S_DEB_DN: begin
        if (key_s_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = S_HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (key_s_q) begin
          cnt_d   = '0;
          short_d = 1'b1;
          state_d = S_DEB_UP;
        end else if (cnt_q == LONG_LAST) begin
          long_evt = 1'b1;
          state_d  = S_LONG_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LONG_DONE: begin
        if (key_s_q) begin
          cnt_d   = '0;
          short_d = 1'b0;
          state_d = S_DEB_UP;
        end
      end
      S_DEB_UP: begin
        // A bounce back to pressed resumes the hold state the press came from.
        if (!key_s_q) begin
          cnt_d   = '0;
          state_d = short_q ? S_HELD : S_LONG_DONE;
        end else if (cnt_q == DEB_LAST) begin
          short_evt = short_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sh_mode_d   = sh_mode_q;
    sh_offset_d = sh_offset_q;
    if (long_evt) begin
      sh_mode_d   = sh_mode_q + 2'd1;
      sh_offset_d = '0;
    end else if (short_evt) begin
      sh_offset_d = sh_offset_q + 4'd1;
    end
    frame_edge = vs_in & ~vs_d_q;
    changed    = (sh_mode_q != mode_q) || (sh_offset_q != offset_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      key_meta_q   <= 1'b1;
      key_s_q      <= 1'b1;
      vs_d_q       <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      short_q      <= 1'b0;
      sh_mode_q    <= 2'd1;
      sh_offset_q  <= 4'd0;
      mode_q       <= 2'd1;
      offset_q     <= 4'd0;
      cfg_update_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      key_meta_q  <= key_n;
      key_s_q     <= key_meta_q;
      vs_d_q      <= vs_in;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      short_q     <= short_d;
      sh_mode_q   <= sh_mode_d;
      sh_offset_q <= sh_offset_d;
      pending_q   <= changed;
      // Commit reads the pre-event shadow, so a same-cycle event waits for the next frame.
      if (frame_edge) begin
        mode_q       <= sh_mode_q;
        offset_q     <= sh_offset_q;
        cfg_update_q <= changed;
      end else begin
        cfg_update_q <= 1'b0;
      end
    end
  end

  assign mode       = mode_q;
  assign offset     = offset_q;
  assign cfg_update = cfg_update_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_hdmi_proc_ctrl.sv
// Self-checking bench for hdmi_proc_ctrl: per-cycle scoreboard against a run-length press model,
// a table of press vectors, and hand sequences for simultaneity and reset mid-press.
module tb_hdmi_proc_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic       pixclk_in;
  logic       rst;
  logic       key_n;
  logic       vs_in;
  logic [1:0] mode;
  logic [3:0] offset;
  logic       cfg_update;
  logic       pending;

  hdmi_proc_ctrl #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .pixclk_in  (pixclk_in),
    .rst        (rst),
    .key_n      (key_n),
    .vs_in      (vs_in),
    .mode       (mode),
    .offset     (offset),
    .cfg_update (cfg_update),
    .pending    (pending)
  );

  initial pixclk_in = 1'b0;
  always #5 pixclk_in = ~pixclk_in;

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;
  int pend_seen = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a press is accepted after DEB+1 consecutive low synchronized samples,
  // released after DEB+1 consecutive highs; LONG low samples while held make it long.
  int m_s1 = 1, m_s2 = 1, m_vs_prev = 0;
  int m_pressed = 0, m_low_run = 0, m_up_run = 0, m_hold = 0, m_long_done = 0;
  int m_sh_mode = 1, m_sh_off = 0, m_mode = 1, m_off = 0, m_upd = 0, m_pend = 0;

  always @(posedge pixclk_in) begin : ref_model
    int k, sev, lev, fe, diff;
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_vs_prev = 0;
      m_pressed = 0; m_low_run = 0; m_up_run = 0; m_hold = 0; m_long_done = 0;
      m_sh_mode = 1; m_sh_off = 0; m_mode = 1; m_off = 0; m_upd = 0; m_pend = 0;
    end else begin
      k = m_s2; sev = 0; lev = 0;
      if (!m_pressed) begin
        m_low_run = k ? 0 : m_low_run + 1;
        if (m_low_run == DEB + 1) begin
          m_pressed = 1; m_hold = 0; m_up_run = 0; m_long_done = 0;
        end
      end else if (k) begin
        m_up_run++;
        if (m_up_run == DEB + 1) begin
          m_pressed = 0; m_low_run = 0; sev = !m_long_done;
        end
      end else if (m_up_run != 0) begin
        m_up_run = 0; m_hold = 0;
      end else if (!m_long_done) begin
        m_hold++;
        if (m_hold == LONG) begin lev = 1; m_long_done = 1; end
      end
      fe   = (vs_in === 1'b1) && (m_vs_prev == 0);
      diff = (m_sh_mode != m_mode) || (m_sh_off != m_off);
      m_pend = diff;
      m_upd  = fe && diff;
      if (fe) begin m_mode = m_sh_mode; m_off = m_sh_off; end
      if (lev) begin m_sh_mode = (m_sh_mode + 1) % 4; m_sh_off = 0; end
      else if (sev) m_sh_off = (m_sh_off + 1) % 16;
      m_s2 = m_s1; m_s1 = int'(key_n); m_vs_prev = int'(vs_in);
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge pixclk_in);
      @(negedge pixclk_in);
      check("mode", int'(mode), m_mode);
      check("offset", int'(offset), m_off);
      check("cfg_update", int'(cfg_update), m_upd);
      check("pending", int'(pending), m_pend);
      if (cfg_update === 1'b1) upd_seen++;
      if (pending === 1'b1) pend_seen++;
    end
  endtask

  task automatic press(input int low_cycles, input int gap);
    key_n = 1'b0;
    cyc(low_cycles);
    key_n = 1'b1;
    cyc(gap);
  endtask

  task automatic frame();
    vs_in = 1'b1;
    cyc(1);
    vs_in = 1'b0;
    cyc(3);
  endtask

  typedef struct {
    int low_cycles;
    int exp_mode;
    int exp_offset;
    int exp_upd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int key_left, vs_left;
    vecs[0] = '{10, 1, 1, 1};
    vecs[1] = '{ 2, 1, 1, 0};
    vecs[2] = '{12, 1, 2, 1};
    vecs[3] = '{ 5, 1, 3, 1};
    vecs[4] = '{40, 2, 0, 1};
    vecs[5] = '{ 4, 2, 0, 0};
    vecs[6] = '{24, 2, 1, 1};
    vecs[7] = '{25, 3, 0, 1};
    vecs[8] = '{30, 0, 0, 1};
    vecs[9] = '{ 7, 0, 1, 1};

    rst = 1'b1; key_n = 1'b1; vs_in = 1'b0;
    cyc(3);
    rst = 1'b0;
    upd_seen = 0; pend_seen = 0;
    for (int f = 0; f < 5; f++) begin
      cyc(4);
      frame();
    end
    check("idle_mode", int'(mode), 1);
    check("idle_offset", int'(offset), 0);
    check("idle_upd_pulses", upd_seen, 0);
    check("idle_pending_cycles", pend_seen, 0);

    for (int v = 0; v < 10; v++) begin
      upd_seen = 0;
      press(vecs[v].low_cycles, 12);
      check("tbl_pending_pre", int'(pending), vecs[v].exp_upd);
      frame();
      check("tbl_mode", int'(mode), vecs[v].exp_mode);
      check("tbl_offset", int'(offset), vecs[v].exp_offset);
      check("tbl_upd_pulses", upd_seen, vecs[v].exp_upd);
    end

    // Wrap-around: start from mode 1 / offset 0 via a long press.
    press(40, 12); frame();
    check("wrap_start_mode", int'(mode), 1);
    for (int i = 0; i < 16; i++) begin
      press(10, 12); frame();
      check("wrap_offset", int'(offset), (i + 1) % 16);
    end
    for (int i = 0; i < 3; i++) begin
      press(40, 12); frame();
      check("wrap_mode", int'(mode), (i + 2) % 4);
      check("wrap_mode_offset", int'(offset), 0);
    end

    // Short event lands on the same edge as the vs_in rise: commit must take the old shadow.
    upd_seen = 0;
    key_n = 1'b0; cyc(10);
    key_n = 1'b1; cyc(6);
    vs_in = 1'b1; cyc(1);
    check("simul_offset_held", int'(offset), 0);
    check("simul_no_upd", upd_seen, 0);
    vs_in = 1'b0; cyc(1);
    check("simul_pending", int'(pending), 1);
    cyc(3);
    frame();
    check("simul_next_offset", int'(offset), 1);
    check("simul_upd_once", upd_seen, 1);

    // Reset while held: everything returns to defaults, then the key is re-debounced.
    key_n = 1'b0; cyc(12);
    rst = 1'b1; cyc(2);
    rst = 1'b0;
    check("rst_mode", int'(mode), 1);
    check("rst_offset", int'(offset), 0);
    cyc(30);
    key_n = 1'b1; cyc(12);
    frame();
    check("rst_long_mode", int'(mode), 2);
    check("rst_long_offset", int'(offset), 0);
    key_n = 1'b0; cyc(12);
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc(15);
    key_n = 1'b1; cyc(12);
    frame();
    check("rst_short_mode", int'(mode), 1);
    check("rst_short_offset", int'(offset), 1);

    // Randomized key bouncing, frame timing and occasional reset against the model.
    key_left = 0; vs_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (key_left == 0) begin
        key_n = ~key_n;
        key_left = $urandom_range(1, 40);
      end else key_left--;
      if (vs_left == 0) begin
        vs_in = ~vs_in;
        vs_left = $urandom_range(2, 25);
      end else vs_left--;
      rst = ($urandom_range(0, 799) == 0);
      cyc(1);
    end
    rst = 1'b0; key_n = 1'b1; vs_in = 1'b0;
    cyc(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
